oflow_core_fsm_fe_ctrl: RTL and testbench
=========================================

// Module: oflow_core_fsm_fe_ctrl
// PURPOSE
//  Per-frame feature-extraction (FE) sequencer for the oflow core. Issues per-set start pulses to the PE array,
//  collects per-PE FE completions, and hands each set to the registration FSM via done_fe.
//  Throttles the next set on registration (frame 0) or score-calc (frame>0) completion.
//  Sits between the core top FSM (upstream) and the registration FSM (downstream).
// PARAMETERS
//  PE_NUM            24    number of processing elements per set
//  SET_LEN           6     width of set count/counter
//  REMAIN_BBOX_LEN   5     width of remaining-bbox count for the last set
//  FRAME_NUM_WIDTH   16    width of frame_num
//  FE_TIMEOUT_CYCLES 1024  watchdog limit, used only with OFLOW_FE_TIMEOUT_EN
// PORTS
//  clk                      in   1                clock, all logic on rising edge
//  reset_N                  in   1                asynchronous active-low reset
//  start_fe                 in   1                core top: start frame, 1-cycle pulse
//  num_of_sets              in   SET_LEN          sets in this frame; stable while busy
//  counter_of_remain_bboxes in   REMAIN_BBOX_LEN  valid PEs in the last set (1..PE_NUM)
//  frame_num                in   FRAME_NUM_WIDTH  current frame index; stable while busy
//  done_fe_i                in   PE_NUM           per-PE FE done; pulse or level
//  done_registration        in   1                from registration FSM
//  done_score_calc          in   1                from registration FSM
//  start_fe_i               out  PE_NUM           per-PE FE start, 1-cycle pulse
//  done_fe                  out  1                to registration FSM: set FE complete, 1-cycle pulse
//  counter_set_fe           out  SET_LEN          index of the set being extracted
//  busy                     out  1                high from accepted start_fe until the frame is done
//  done_frame_fe            out  1                1-cycle pulse after the last set is released
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; done_seen register 0. Asynchronous reset mid-frame aborts the frame.
//  Mask: set counter_set_fe < num_of_sets-1 -> all PE_NUM bits.
//   Last set -> low counter_of_remain_bboxes bits; a value of 0 or > PE_NUM is treated as PE_NUM.
//  States:
//   IDLE: start_fe && num_of_sets != 0 -> ISSUE.
//    start_fe with num_of_sets == 0 -> done_frame_fe next cycle; stays IDLE.
//    start_fe while busy is ignored.
//   ISSUE (1 cycle): start_fe_i = mask; done_seen cleared -> WAIT_FE.
//   WAIT_FE: done_seen |= done_fe_i & mask each cycle.
//    When (done_seen | (done_fe_i & mask)) == mask -> done_fe = 1 that cycle -> WAIT_NEXT.
//    This completion uses the same-cycle bypass, so FE latency is zero extra cycles.
//    Bits outside the mask are ignored.
//   WAIT_NEXT: release condition is frame_num==0 ? done_registration : done_score_calc.
//    Not last set -> counter_set_fe + 1 -> ISSUE.
//    Last set -> done_frame_fe pulse; counter_set_fe <= 0 -> IDLE.
//  A release arriving in the same cycle as done_fe is not seen; release is sampled only in WAIT_NEXT.
//  counter_set_fe: 0 in IDLE and on reset; increments only on a WAIT_NEXT release; never exceeds num_of_sets-1.
//  busy = (state != IDLE).
//  Minimum per-set latency: ISSUE -> done_fe is 1 cycle when done_fe_i arrives immediately.
// CONFIGURATION
//  OFLOW_FE_TIMEOUT_EN defined:
//   - 16-bit watchdog counts cycles in WAIT_FE.
//   - At FE_TIMEOUT_CYCLES it forces done_fe and moves to WAIT_NEXT.
//   - Adds output fe_timeout (1 bit), sticky until reset or the next accepted start_fe.
//  OFLOW_FE_TIMEOUT_EN undefined: no watchdog and no fe_timeout port; WAIT_FE waits indefinitely.
// TESTING
//  1. num_of_sets=3, remain=24, frame 0; all done_fe_i after 5 cycles; done_registration 4 cycles later
//     -> 3 done_fe pulses, counter_set_fe 0,1,2; one done_frame_fe; start_fe_i=24'hFFFFFF each set.
//  2. num_of_sets=2, remain=5, frame 7: last set start_fe_i=24'h00001F; done_fe_i=24'hFFFFFF there
//     -> done_fe still a single pulse; release only on done_score_calc; done_registration ignored.
//  3. Staggered done_fe_i pulses, one PE per cycle over 24 cycles -> done_fe on the cycle the 24th bit arrives, not earlier.
//  4. start_fe with num_of_sets=0 -> no start_fe_i; done_frame_fe 1 cycle later; busy stays 0.
//  5. reset_N low in WAIT_FE of set 1 -> outputs 0 immediately; a new start_fe then restarts at set 0.
//  6. (OFLOW_FE_TIMEOUT_EN, FE_TIMEOUT_CYCLES=16) one PE never completes -> done_fe at cycle 16, fe_timeout=1.

Source files
------------

// File: rtl/oflow_core_fsm_fe_ctrl.sv
// Feature-extraction sequencer: issues per-set PE starts, gathers PE completions, paces sets on downstream release.
// Optional watchdog on the FE wait (adds fe_timeout) is enabled by defining OFLOW_FE_TIMEOUT_EN.
module oflow_core_fsm_fe_ctrl #(
  parameter int PE_NUM            = 24,
  parameter int SET_LEN           = 6,
  parameter int REMAIN_BBOX_LEN   = 5,
  parameter int FRAME_NUM_WIDTH   = 16,
  parameter int FE_TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset_N,
  input  logic                       start_fe,
  input  logic [SET_LEN-1:0]         num_of_sets,
  input  logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes,
  input  logic [FRAME_NUM_WIDTH-1:0] frame_num,
  input  logic [PE_NUM-1:0]          done_fe_i,
  input  logic                       done_registration,
  input  logic                       done_score_calc,
  output logic [PE_NUM-1:0]          start_fe_i,
  output logic                       done_fe,
  output logic [SET_LEN-1:0]         counter_set_fe,
  output logic                       busy,
`ifdef OFLOW_FE_TIMEOUT_EN
  output logic                       fe_timeout,
`endif
  output logic                       done_frame_fe
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FE, WAIT_NEXT} state_t;

  state_t               state;
  logic [PE_NUM-1:0]    done_seen;
  logic [PE_NUM-1:0]    cur_mask;
  logic [SET_LEN-1:0]   last_idx;
  logic [SET_LEN-1:0]   next_set;
  logic                 last_set;
  logic                 fe_all;
  logic                 release_ok;

  // Only the last set may be partial; an out-of-range remainder means a full set.
  function automatic logic [PE_NUM-1:0] set_mask(input logic                       is_last,
                                                  input logic [REMAIN_BBOX_LEN-1:0] remain);
    logic [PE_NUM-1:0] m;
    m = '1;
    if (is_last && (remain != '0) && (int'(remain) < PE_NUM))
      m = m >> (PE_NUM - int'(remain));
    return m;
  endfunction

  assign last_idx   = num_of_sets - SET_LEN'(1);
  assign next_set   = counter_set_fe + SET_LEN'(1);
  assign last_set   = (counter_set_fe == last_idx);
  assign cur_mask   = set_mask(last_set, counter_of_remain_bboxes);
  assign release_ok = (frame_num == '0) ? done_registration : done_score_calc;
  assign busy       = (state != IDLE);

  // Same-cycle bypass: a set completes on the cycle its final PE reports.
  assign fe_all = (state == WAIT_FE) && ((done_seen | (done_fe_i & cur_mask)) == cur_mask);

`ifdef OFLOW_FE_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        wd_hit;
  assign wd_hit  = (state == WAIT_FE) && (wd_cnt == 16'(FE_TIMEOUT_CYCLES - 1));
  assign done_fe = fe_all || wd_hit;
`else
  assign done_fe = fe_all;
`endif

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state          <= IDLE;
      counter_set_fe <= '0;
      done_seen      <= '0;
      start_fe_i     <= '0;
      done_frame_fe  <= 1'b0;
`ifdef OFLOW_FE_TIMEOUT_EN
      wd_cnt         <= '0;
      fe_timeout     <= 1'b0;
`endif
    end else begin
      start_fe_i    <= '0;
      done_frame_fe <= 1'b0;
      case (state)
        IDLE: begin
          if (start_fe) begin
            counter_set_fe <= '0;
`ifdef OFLOW_FE_TIMEOUT_EN
            fe_timeout     <= 1'b0;
`endif
            if (num_of_sets != '0) begin
              start_fe_i <= set_mask(num_of_sets == SET_LEN'(1), counter_of_remain_bboxes);
              state      <= ISSUE;
            end else begin
              done_frame_fe <= 1'b1;
            end
          end
        end
        ISSUE: begin
          done_seen <= '0;
`ifdef OFLOW_FE_TIMEOUT_EN
          wd_cnt    <= '0;
`endif
          state     <= WAIT_FE;
        end
        WAIT_FE: begin
          done_seen <= done_seen | (done_fe_i & cur_mask);
`ifdef OFLOW_FE_TIMEOUT_EN
          wd_cnt    <= wd_cnt + 16'd1;
          if (wd_hit && !fe_all)
            fe_timeout <= 1'b1;
`endif
          if (done_fe)
            state <= WAIT_NEXT;
        end
        WAIT_NEXT: begin
          if (release_ok) begin
            if (last_set) begin
              counter_set_fe <= '0;
              done_frame_fe  <= 1'b1;
              state          <= IDLE;
            end else begin
              counter_set_fe <= next_set;
              start_fe_i     <= set_mask(next_set == last_idx, counter_of_remain_bboxes);
              state          <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oflow_core_fsm_fe_ctrl.sv
// Bench for oflow_core_fsm_fe_ctrl: frame-level behavioural model checked every cycle plus directed literal checks.
// Defining OFLOW_FE_TIMEOUT_EN also exercises the watchdog with a 16-cycle limit.
module tb_oflow_core_fsm_fe_ctrl;
  localparam int PE = 24;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_N;
  logic        start_fe;
  logic [5:0]  num_of_sets;
  logic [4:0]  counter_of_remain_bboxes;
  logic [15:0] frame_num;
  logic [23:0] done_fe_i;
  logic        done_registration;
  logic        done_score_calc;
  logic [23:0] start_fe_i;
  logic        done_fe;
  logic [5:0]  counter_set_fe;
  logic        busy;
  logic        done_frame_fe;
`ifdef OFLOW_FE_TIMEOUT_EN
  logic        fe_timeout;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int n_done_fe = 0;
  int n_dframe  = 0;

  oflow_core_fsm_fe_ctrl #(.FE_TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_N(reset_N), .start_fe(start_fe), .num_of_sets(num_of_sets),
    .counter_of_remain_bboxes(counter_of_remain_bboxes), .frame_num(frame_num),
    .done_fe_i(done_fe_i), .done_registration(done_registration), .done_score_calc(done_score_calc),
    .start_fe_i(start_fe_i), .done_fe(done_fe), .counter_set_fe(counter_set_fe), .busy(busy),
`ifdef OFLOW_FE_TIMEOUT_EN
    .fe_timeout(fe_timeout),
`endif
    .done_frame_fe(done_frame_fe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Enabled PEs for a set: the last set holds only the remaining boxes.
  function automatic logic [23:0] mask_of(input int s, input int nsets, input int remain);
    logic [23:0] m;
    int n;
    n = PE;
    if (s == nsets - 1 && remain != 0 && remain <= PE) n = remain;
    m = '0;
    for (int i = 0; i < PE; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  // Frame model: a frame is a list of sets; each set is issued, its outstanding PEs are retired,
  // then it waits for the frame-dependent release before the next set (or frame end).
  bit          m_busy, m_issue, m_in_fe, m_fpulse, m_to;
  int          m_set, m_nsets, m_fe_cyc;
  logic [23:0] m_mask, m_got;

  always @(negedge clk) begin
    logic [23:0] e_start;
    logic        e_done, to_now, nxt_pulse, rel;
    if (!reset_N) begin
      m_busy = 0; m_issue = 0; m_in_fe = 0; m_fpulse = 0; m_to = 0;
      m_set = 0; m_nsets = 0; m_fe_cyc = 0; m_mask = '0; m_got = '0;
    end
    e_start = m_issue ? m_mask : 24'h0;
    e_done  = m_in_fe && ((m_got | (done_fe_i & m_mask)) == m_mask);
    to_now  = 1'b0;
`ifdef OFLOW_FE_TIMEOUT_EN
    if (m_in_fe && m_fe_cyc == TO - 1) begin
      to_now = !e_done;
      e_done = 1'b1;
    end
    check("m_fe_timeout", 32'(fe_timeout), 32'(m_to));
`endif
    check("m_start_fe_i", 32'(start_fe_i), 32'(e_start));
    check("m_done_fe", 32'(done_fe), 32'(e_done));
    check("m_counter_set_fe", 32'(counter_set_fe), 32'(m_set));
    check("m_busy", 32'(busy), 32'(m_busy));
    check("m_done_frame_fe", 32'(done_frame_fe), 32'(m_fpulse));
    if (done_fe) n_done_fe++;
    if (done_frame_fe) n_dframe++;
    if (reset_N) begin
      nxt_pulse = 1'b0;
      if (!m_busy) begin
        if (start_fe) begin
          m_to = 0;
          if (num_of_sets == 0) nxt_pulse = 1'b1;
          else begin
            m_busy = 1; m_nsets = int'(num_of_sets); m_set = 0; m_issue = 1;
            m_mask = mask_of(0, m_nsets, int'(counter_of_remain_bboxes));
          end
        end
      end else if (m_issue) begin
        m_issue = 0; m_in_fe = 1; m_got = '0; m_fe_cyc = 0;
      end else if (m_in_fe) begin
        m_got = m_got | (done_fe_i & m_mask);
        m_fe_cyc++;
        if (e_done) begin
          m_in_fe = 0;
          if (to_now) m_to = 1;
        end
      end else begin
        rel = (frame_num == 0) ? done_registration : done_score_calc;
        if (rel) begin
          if (m_set == m_nsets - 1) begin
            m_busy = 0; m_set = 0; nxt_pulse = 1'b1;
          end else begin
            m_set++; m_issue = 1;
            m_mask = mask_of(m_set, m_nsets, int'(counter_of_remain_bboxes));
          end
        end
      end
      m_fpulse = nxt_pulse;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_fe = 1'b1;
    tick();
    start_fe = 1'b0;
  endtask

  task automatic wait_start(output logic [23:0] v);
    int n;
    n = 0;
    while (start_fe_i == 24'h0 && n < 50) begin
      tick();
      n++;
    end
    check("wait_start_bound", 32'(n < 50), 32'd1);
    v = start_fe_i;
  endtask

  task automatic pulse_release(input bit reg_not_score);
    if (reg_not_score) done_registration = 1'b1;
    else done_score_calc = 1'b1;
    tick();
    done_registration = 1'b0;
    done_score_calc   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] v;
    int first, n;
    reset_N = 1'b0; start_fe = 1'b0; num_of_sets = 6'd0; counter_of_remain_bboxes = 5'd0;
    frame_num = 16'd0; done_fe_i = '0; done_registration = 1'b0; done_score_calc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_fe_i", 32'(start_fe_i), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_counter", 32'(counter_set_fe), 32'h0);
    check("rst_done_frame", 32'(done_frame_fe), 32'h0);
    reset_N = 1'b1;
    tick();

    // 1: three full sets, frame 0; a start_fe while busy is ignored
    n_done_fe = 0; n_dframe = 0;
    num_of_sets = 6'd3; counter_of_remain_bboxes = 5'd24; frame_num = 16'd0;
    pulse_start();
    for (int s = 0; s < 3; s++) begin
      wait_start(v);
      check("t1_mask", 32'(v), 32'h00FFFFFF);
      check("t1_set", 32'(counter_set_fe), s);
      if (s == 1) begin
        start_fe = 1'b1; tick(); start_fe = 1'b0; repeat (4) tick();
      end else repeat (5) tick();
      done_fe_i = 24'hFFFFFF;
      #1 check("t1_done_fe", 32'(done_fe), 32'd1);
      tick();
      done_fe_i = '0;
      repeat (3) tick();
      pulse_release(1'b1);
    end
    check("t1_done_frame", 32'(done_frame_fe), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    tick();
    check("t1_n_done_fe", n_done_fe, 3);
    check("t1_n_dframe", n_dframe, 1);

    // 2: frame 7, partial last set, release only on done_score_calc
    n_done_fe = 0; n_dframe = 0;
    num_of_sets = 6'd2; counter_of_remain_bboxes = 5'd5; frame_num = 16'd7;
    pulse_start();
    wait_start(v);
    check("t2_mask0", 32'(v), 32'h00FFFFFF);
    tick();
    done_fe_i = 24'hFFFFFF; done_score_calc = 1'b1;
    #1 check("t2_done_fe0", 32'(done_fe), 32'd1);
    tick();
    done_fe_i = '0; done_score_calc = 1'b0;
    repeat (2) tick();
    done_registration = 1'b1;
    repeat (2) tick();
    done_registration = 1'b0;
    check("t2_reg_ignored", 32'(counter_set_fe), 32'd0);
    check("t2_still_busy", 32'(busy), 32'd1);
    pulse_release(1'b0);
    wait_start(v);
    check("t2_mask1", 32'(v), 32'h0000001F);
    check("t2_set1", 32'(counter_set_fe), 32'd1);
    tick();
    done_fe_i = 24'hFFFFFF;
    #1 check("t2_done_fe1", 32'(done_fe), 32'd1);
    tick();
    check("t2_single_pulse", 32'(done_fe), 32'd0);
    tick();
    done_fe_i = '0;
    pulse_release(1'b0);
    check("t2_done_frame", 32'(done_frame_fe), 32'd1);
    tick();
    check("t2_n_done_fe", n_done_fe, 2);

    // 3: staggered completions, remain=0 means a full set
    num_of_sets = 6'd1; counter_of_remain_bboxes = 5'd0; frame_num = 16'd0;
    pulse_start();
    wait_start(v);
    check("t3_mask", 32'(v), 32'h00FFFFFF);
    tick();
    first = -1;
    for (int i = 0; i < PE; i++) begin
      done_fe_i = 24'h000001 << i;
      #1 if (done_fe && first < 0) first = i;
      tick();
    end
    check("t3_done_at_24th", first, 23);
    done_fe_i = '0;
    pulse_release(1'b1);
    check("t3_done_frame", 32'(done_frame_fe), 32'd1);
    tick();

    // 4: empty frame
    num_of_sets = 6'd0;
    start_fe = 1'b1;
    #1 check("t4_busy_start", 32'(busy), 32'd0);
    tick();
    start_fe = 1'b0;
    check("t4_done_frame", 32'(done_frame_fe), 32'd1);
    check("t4_no_start", 32'(start_fe_i), 32'h0);
    check("t4_busy", 32'(busy), 32'd0);
    tick();
    check("t4_pulse_end", 32'(done_frame_fe), 32'd0);

    // 5: reset during WAIT_FE of set 1, then a fresh frame
    num_of_sets = 6'd3; counter_of_remain_bboxes = 5'd24; frame_num = 16'd0;
    pulse_start();
    wait_start(v);
    tick();
    done_fe_i = 24'hFFFFFF;
    tick();
    done_fe_i = '0;
    pulse_release(1'b1);
    wait_start(v);
    check("t5_set1", 32'(counter_set_fe), 32'd1);
    repeat (2) tick();
    reset_N = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_counter", 32'(counter_set_fe), 32'd0);
    check("t5_rst_done_fe", 32'(done_fe), 32'd0);
    repeat (2) tick();
    reset_N = 1'b1;
    tick();
    num_of_sets = 6'd1;
    pulse_start();
    wait_start(v);
    check("t5_restart_set", 32'(counter_set_fe), 32'd0);
    tick();
    done_fe_i = 24'hFFFFFF;
    tick();
    done_fe_i = '0;
    pulse_release(1'b1);
    check("t5_done_frame", 32'(done_frame_fe), 32'd1);
    tick();

`ifdef OFLOW_FE_TIMEOUT_EN
    // 6: one PE never reports; the watchdog completes the set
    num_of_sets = 6'd1; counter_of_remain_bboxes = 5'd2; frame_num = 16'd0;
    pulse_start();
    wait_start(v);
    check("t6_mask", 32'(v), 32'h00000003);
    tick();
    done_fe_i = 24'h000001;
    n = 1;
    #1;
    while (!done_fe && n < 40) begin
      tick();
      n++;
    end
    check("t6_timeout_cycle", n, TO);
    tick();
    check("t6_fe_timeout", 32'(fe_timeout), 32'd1);
    done_fe_i = '0;
    pulse_release(1'b1);
    check("t6_sticky", 32'(fe_timeout), 32'd1);
    num_of_sets = 6'd0;
    pulse_start();
    check("t6_cleared", 32'(fe_timeout), 32'd0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
